mac_operand_ser: RTL and testbench

Bit-serial operand transmitter for the `mac` block. It accepts one parallel operand set (A, B, C) per frame and drives the MAC's serial inputs `A`/`B`/`C` and `START`, LSB first. It waits for the MAC's `READY` before starting each frame. It sits directly upstream of `mac`, and its outputs connect one-to-one to the MAC inputs.

---
 rtl/mac_pkg.sv | 20 ++
 rtl/mac_operand_ser_if.sv | 26 ++
 rtl/mac_ser_buf.sv | 60 ++++++
 rtl/mac_operand_ser.sv | 162 ++++++++++++++++
 tb/tb_mac_operand_ser.sv | 284 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mac_pkg.sv
// Shared types and sizing helpers for the mac operand serializer.
package mac_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        SHIFT
    } ser_state_e;

    localparam int MAC_W_DEFAULT = 4;

    function automatic int frame_len(input int w);
        return 2 * w;
    endfunction

    function automatic int cnt_width(input int w);
        return $clog2(2 * w);
    endfunction

endpackage

// File: rtl/mac_operand_ser_if.sv
// Parallel operand handshake plus serial MAC-side signals of mac_operand_ser.
interface mac_operand_ser_if #(
    parameter int W = mac_pkg::MAC_W_DEFAULT
);
    logic           IN_VALID;
    logic           IN_READY;
    logic [W-1:0]   IN_A;
    logic [W-1:0]   IN_B;
    logic [2*W-1:0] IN_C;
    logic           MAC_READY;
    logic           A;
    logic           B;
    logic           C;
    logic           START;
    logic           DONE;

    modport master (
        output IN_VALID, IN_A, IN_B, IN_C, MAC_READY,
        input  IN_READY, A, B, C, START, DONE
    );

    modport slave (
        input  IN_VALID, IN_A, IN_B, IN_C, MAC_READY,
        output IN_READY, A, B, C, START, DONE
    );
endinterface

// File: rtl/mac_ser_buf.sv
// One-entry operand holding register with full flag; only present when
// MAC_SER_BUF_EN is defined.
`ifdef MAC_SER_BUF_EN
module mac_ser_buf
    import mac_pkg::*;
#(
    parameter int W = MAC_W_DEFAULT
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           load,
    input  logic           drain,
    input  logic [W-1:0]   in_a,
    input  logic [W-1:0]   in_b,
    input  logic [2*W-1:0] in_c,
    output logic           full,
    output logic [W-1:0]   out_a,
    output logic [W-1:0]   out_b,
    output logic [2*W-1:0] out_c
);
    logic           full_q, full_d;
    logic [W-1:0]   a_q, a_d, b_q, b_d;
    logic [2*W-1:0] c_q, c_d;

    // A load on the same edge as a drain refills the entry.
    always_comb begin
        full_d = full_q;
        a_d    = a_q;
        b_d    = b_q;
        c_d    = c_q;
        if (load) begin
            full_d = 1'b1;
            a_d    = in_a;
            b_d    = in_b;
            c_d    = in_c;
        end else if (drain) begin
            full_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            full_q <= 1'b0;
            a_q    <= '0;
            b_q    <= '0;
            c_q    <= '0;
        end else begin
            full_q <= full_d;
            a_q    <= a_d;
            b_q    <= b_d;
            c_q    <= c_d;
        end
    end

    assign full  = full_q;
    assign out_a = a_q;
    assign out_b = b_q;
    assign out_c = c_q;
endmodule
`endif

// File: rtl/mac_operand_ser.sv
// Bit-serial operand transmitter feeding the mac block, LSB first, 2W-cycle frames.
// Define MAC_SER_BUF_EN to add a one-entry holding buffer for back-to-back frames.
module mac_operand_ser
    import mac_pkg::*;
#(
    parameter int W = MAC_W_DEFAULT
) (
    input  logic            CLK,
    input  logic            RST,
    mac_operand_ser_if.slave bus
);
    localparam int            FRAME = frame_len(W);
    localparam int            CW    = cnt_width(W);
    localparam logic [CW-1:0] LAST  = CW'(FRAME - 1);

    ser_state_e     state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [W-1:0]   sa_q, sa_d, sb_q, sb_d;
    logic [2*W-1:0] sc_q, sc_d;
    logic           a_q, a_d, b_q, b_d, c_q, c_d;
    logic           start_q, start_d, done_q, done_d;

    logic           in_ready, accept, frame_end, regs_free, have_src;
    logic [W-1:0]   src_a, src_b;
    logic [2*W-1:0] src_c;

`ifdef MAC_SER_BUF_EN
    logic           buf_full, buf_load, buf_drain;
    logic [W-1:0]   buf_a, buf_b;
    logic [2*W-1:0] buf_c;

    mac_ser_buf #(.W(W)) u_buf (
        .clk   (CLK),
        .rst   (RST),
        .load  (buf_load),
        .drain (buf_drain),
        .in_a  (bus.IN_A),
        .in_b  (bus.IN_B),
        .in_c  (bus.IN_C),
        .full  (buf_full),
        .out_a (buf_a),
        .out_b (buf_b),
        .out_c (buf_c)
    );

    assign in_ready = !buf_full;
`else
    assign in_ready = (state_q == IDLE);
`endif

    // A frame source (WAIT regs, buffer, or fresh input) starts only when MAC_READY is high.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        sa_d      = sa_q;
        sb_d      = sb_q;
        sc_d      = sc_q;
        a_d       = 1'b0;
        b_d       = 1'b0;
        c_d       = 1'b0;
        start_d   = 1'b0;
        done_d    = 1'b0;
        have_src  = 1'b0;
        src_a     = sa_q;
        src_b     = sb_q;
        src_c     = sc_q;
        accept    = bus.IN_VALID && in_ready;
        frame_end = (state_q == SHIFT) && (cnt_q == LAST);
        regs_free = (state_q == IDLE) || frame_end;
`ifdef MAC_SER_BUF_EN
        buf_drain = regs_free && buf_full;
        buf_load  = accept && !(regs_free && !buf_full);
`endif

        if (state_q == WAIT) begin
            have_src = 1'b1;
        end

        if ((state_q == SHIFT) && !frame_end) begin
            a_d    = sa_q[0];
            b_d    = sb_q[0];
            c_d    = sc_q[0];
            sa_d   = sa_q >> 1;
            sb_d   = sb_q >> 1;
            sc_d   = sc_q >> 1;
            cnt_d  = cnt_q + 1'b1;
            done_d = (cnt_q == LAST - 1'b1);
        end

        if (regs_free) begin
`ifdef MAC_SER_BUF_EN
            if (buf_full) begin
                have_src = 1'b1;
                src_a    = buf_a;
                src_b    = buf_b;
                src_c    = buf_c;
            end else
`endif
            if (accept) begin
                have_src = 1'b1;
                src_a    = bus.IN_A;
                src_b    = bus.IN_B;
                src_c    = bus.IN_C;
            end
            if (!have_src) begin
                state_d = IDLE;
            end
        end

        if (have_src) begin
            if (bus.MAC_READY) begin
                state_d = SHIFT;
                cnt_d   = '0;
                a_d     = src_a[0];
                b_d     = src_b[0];
                c_d     = src_c[0];
                start_d = 1'b1;
                sa_d    = src_a >> 1;
                sb_d    = src_b >> 1;
                sc_d    = src_c >> 1;
            end else begin
                state_d = WAIT;
                sa_d    = src_a;
                sb_d    = src_b;
                sc_d    = src_c;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            sa_q    <= '0;
            sb_q    <= '0;
            sc_q    <= '0;
            a_q     <= 1'b0;
            b_q     <= 1'b0;
            c_q     <= 1'b0;
            start_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            sc_q    <= sc_d;
            a_q     <= a_d;
            b_q     <= b_d;
            c_q     <= c_d;
            start_q <= start_d;
            done_q  <= done_d;
        end
    end

    assign bus.IN_READY = in_ready;
    assign bus.A        = a_q;
    assign bus.B        = b_q;
    assign bus.C        = c_q;
    assign bus.START    = start_q;
    assign bus.DONE     = done_q;
endmodule

// File: tb/tb_mac_operand_ser.sv
// Bench for mac_operand_ser: operand sets are queued on acceptance and a monitor
// scores each serial frame; define MAC_SER_BUF_EN to exercise the buffered build.
module tb_mac_operand_ser;
    localparam int W     = 4;
    localparam int CWID  = 2 * W;
    localparam int FRAME = 2 * W;
`ifdef MAC_SER_BUF_EN
    localparam int CAP = 2;
`else
    localparam int CAP = 1;
`endif

    typedef struct packed {
        logic [W-1:0]    a;
        logic [W-1:0]    b;
        logic [CWID-1:0] c;
    } op_set_t;

    logic    clk;
    logic    rst_drv;
    logic    in_valid;
    logic    mac_ready;
    op_set_t drv_set;
    bit      rand_mac;
    bit      mon_en;

    int      n_checks;
    int      n_fail;
    int      cyc;
    int      epoch;
    int      remaining;
    bit      acc_last;
    bit      mdl_ready;
    op_set_t wait_q[$];
    op_set_t sb_q[$];
    int      exp_start_q[$];

    mac_operand_ser_if #(.W(W)) bus ();

    mac_operand_ser #(.W(W)) dut (
        .CLK (clk),
        .RST (rst_drv),
        .bus (bus)
    );

    assign bus.IN_VALID  = in_valid;
    assign bus.IN_A      = drv_set.a;
    assign bus.IN_B      = drv_set.b;
    assign bus.IN_C      = drv_set.c;
    assign bus.MAC_READY = mac_ready;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    // Frame-level model: a FIFO of loaded sets, a cycles-left counter for the frame
    // on the wire, and a capacity of one set (two with the holding buffer).
    initial begin : model
        remaining = 0;
        cyc       = 0;
        epoch     = 0;
        acc_last  = 1'b0;
        mdl_ready = 1'b1;
        forever begin
            @(posedge clk);
            cyc++;
            acc_last = 1'b0;
            if (rst_drv) begin
                wait_q.delete();
                sb_q.delete();
                exp_start_q.delete();
                remaining = 0;
                epoch++;
            end else begin
                acc_last = in_valid && mdl_ready;
                if (remaining > 0) remaining--;
                if (acc_last) begin
                    wait_q.push_back(drv_set);
                    sb_q.push_back(drv_set);
                end
                if (remaining == 0 && wait_q.size() > 0 && mac_ready) begin
                    wait_q.delete(0);
                    exp_start_q.push_back(cyc);
                    remaining = FRAME;
                end
            end
            mdl_ready = (((remaining > 0) ? 1 : 0) + wait_q.size()) < CAP;
        end
    end

    initial begin : monitor
        bit      in_frame;
        int      pos;
        int      seen_epoch;
        int      exp_cyc;
        op_set_t cur;
        logic    ea, eb, ec;
        in_frame   = 1'b0;
        pos        = 0;
        seen_epoch = 0;
        cur        = '0;
        wait (mon_en);
        forever begin
            @(negedge clk);
            if (epoch != seen_epoch) begin
                seen_epoch = epoch;
                in_frame   = 1'b0;
            end
            if (!in_frame && bus.START === 1'b1) begin
                if (sb_q.size() == 0 || exp_start_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("[TB] FAIL unexpected START: got START=1 with no frame due (cycle %0d)", cyc);
                end else begin
                    cur      = sb_q.pop_front();
                    exp_cyc  = exp_start_q.pop_front();
                    in_frame = 1'b1;
                    pos      = 0;
                    checkOutput("start cycle", 32'(cyc), 32'(exp_cyc));
                end
            end
            if (in_frame) begin
                ea = (pos < W) ? 1'(cur.a >> pos) : 1'b0;
                eb = (pos < W) ? 1'(cur.b >> pos) : 1'b0;
                ec = 1'(cur.c >> pos);
                checkOutput("A bit", 32'(bus.A), 32'(ea));
                checkOutput("B bit", 32'(bus.B), 32'(eb));
                checkOutput("C bit", 32'(bus.C), 32'(ec));
                checkOutput("START", 32'(bus.START), 32'(pos == 0));
                checkOutput("DONE", 32'(bus.DONE), 32'(pos == FRAME - 1));
                pos++;
                if (pos == FRAME) in_frame = 1'b0;
            end else begin
                checkOutput("idle outputs", 32'({bus.A, bus.B, bus.C, bus.START, bus.DONE}), 32'd0);
            end
            checkOutput("IN_READY", 32'(bus.IN_READY), 32'(mdl_ready));
        end
    end

    initial begin : mac_ready_noise
        forever begin
            @(negedge clk);
            if (rand_mac) mac_ready = ($urandom_range(0, 3) != 0);
        end
    end

    initial begin : watchdog
        #500000;
        $display("[TB] FAIL watchdog: time limit reached before end of test");
        $fatal(1, "[TB] watchdog expired");
    end

    // Presents a set and holds IN_VALID until the model accepts it; IN_VALID stays high.
    task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b, input logic [CWID-1:0] c);
        int budget;
        drv_set.a = a;
        drv_set.b = b;
        drv_set.c = c;
        in_valid  = 1'b1;
        budget    = 0;
        do begin
            @(negedge clk);
            budget++;
        end while (!acc_last && budget < 300);
        if (!acc_last) begin
            n_checks++;
            n_fail++;
            $display("[TB] FAIL accept timeout: set not accepted after %0d cycles, required acceptance", budget);
            in_valid = 1'b0;
        end
    endtask

    task automatic idleInputs();
        in_valid  = 1'b0;
        drv_set.a = W'($urandom);
        drv_set.b = W'($urandom);
        drv_set.c = CWID'($urandom);
    endtask

    task automatic waitIdle();
        int budget;
        budget = 0;
        while ((remaining != 0 || wait_q.size() != 0) && budget < 400) begin
            @(negedge clk);
            budget++;
        end
        if (remaining != 0 || wait_q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("[TB] FAIL drain timeout: %0d sets still pending, required 0", wait_q.size());
        end
        @(negedge clk);
    endtask

    initial begin : stimulus
        n_checks  = 0;
        n_fail    = 0;
        rst_drv   = 1'b1;
        in_valid  = 1'b0;
        mac_ready = 1'b1;
        rand_mac  = 1'b0;
        mon_en    = 1'b0;
        drv_set   = '0;
        repeat (3) @(negedge clk);
        rst_drv = 1'b0;
        mon_en  = 1'b1;
        @(negedge clk);

        $display("[TB] basic frame");
        applyStimulus(4'hF, 4'hF, 8'h7F);
        idleInputs();
        waitIdle();

        $display("[TB] bit ordering");
        applyStimulus(4'h5, 4'hA, 8'h77);
        idleInputs();
        waitIdle();

        $display("[TB] hold-off then MAC_READY drop mid-frame");
        mac_ready = 1'b0;
        applyStimulus(4'h3, 4'hC, 8'hA5);
        idleInputs();
        repeat (3) @(negedge clk);
        mac_ready = 1'b1;
        repeat (3) @(negedge clk);
        mac_ready = 1'b0;
        waitIdle();
        mac_ready = 1'b1;

        $display("[TB] reset mid-frame");
        applyStimulus(4'h9, 4'h6, 8'hC3);
        idleInputs();
        repeat (3) @(negedge clk);
        rst_drv = 1'b1;
        @(negedge clk);
        rst_drv = 1'b0;
        @(negedge clk);
        applyStimulus(4'hE, 4'h1, 8'h5A);
        idleInputs();
        waitIdle();

        $display("[TB] back-pressure with two sets");
        applyStimulus(4'h2, 4'h7, 8'h81);
        applyStimulus(4'hB, 4'h4, 8'h3C);
        idleInputs();
        waitIdle();

        $display("[TB] three sets back-to-back");
        applyStimulus(4'h1, 4'h8, 8'hF0);
        applyStimulus(4'h6, 4'h9, 8'h0F);
        applyStimulus(4'hD, 4'h2, 8'h99);
        idleInputs();
        waitIdle();

        $display("[TB] random traffic");
        rand_mac = 1'b1;
        for (int n = 0; n < 40; n++) begin
            applyStimulus(W'($urandom), W'($urandom), CWID'($urandom));
            if ($urandom_range(0, 2) == 0) begin
                idleInputs();
                repeat ($urandom_range(0, 3)) @(negedge clk);
            end
        end
        idleInputs();
        rand_mac = 1'b0;
        @(negedge clk);
        mac_ready = 1'b1;
        waitIdle();
        repeat (2) @(negedge clk);
        checkOutput("frames outstanding", 32'(sb_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
